// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS32 ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding, load-use bubble insertion, stall and flush handling.
// Revision: 1.0

`default_nettype none

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic [2:0]    id_alu_control,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dest,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dest,
  input  logic [DW-1:0] memwb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [2:0]    ex_alu_control,
  output logic [RW-1:0] ex_dest,
  output logic [DW-1:0] ex_pc,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_hazard
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dest;
    logic          alu_src;
    logic [2:0]    alu_ctl;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } stage_t;

  stage_t        st_q, st_d;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // EX/MEM has priority over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_rs = st_q.rs_data;
    if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == st_q.rs)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == st_q.rs)) begin
      fwd_rs = memwb_data;
    end
  end

  always_comb begin
    fwd_rt = st_q.rt_data;
    if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == st_q.rt)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == st_q.rt)) begin
      fwd_rt = memwb_data;
    end
  end

  // rt only matters when it is an ALU source or store data.
  always_comb begin
    load_use_hazard = 1'b0;
    if (st_q.valid && st_q.mem_read && (st_q.dest != '0) && id_valid) begin
      load_use_hazard = (st_q.dest == id_rs) ||
                        ((st_q.dest == id_rt) && (!id_alu_src || id_mem_write));
    end
  end

  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else if (stall) begin
      // Refresh operands so a write retiring during the stall is captured.
      st_d.rs_data = fwd_rs;
      st_d.rt_data = fwd_rt;
    end else if (load_use_hazard) begin
      st_d = '0;
    end else begin
      st_d.valid      = id_valid;
      st_d.pc         = id_pc;
      st_d.rs_data    = id_rs_data;
      st_d.rt_data    = id_rt_data;
      st_d.imm        = id_imm;
      st_d.rs         = id_rs;
      st_d.rt         = id_rt;
      st_d.dest       = id_reg_dst ? id_rd : id_rt;
      st_d.alu_src    = id_alu_src;
      st_d.alu_ctl    = id_valid ? id_alu_control : 3'b000;
      st_d.reg_write  = id_valid & id_reg_write;
      st_d.mem_read   = id_valid & id_mem_read;
      st_d.mem_write  = id_valid & id_mem_write;
      st_d.mem_to_reg = id_valid & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign ex_valid       = st_q.valid;
  assign ex_a           = fwd_rs;
  assign ex_b           = st_q.alu_src ? st_q.imm : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_alu_control = st_q.alu_ctl;
  assign ex_dest        = st_q.dest;
  assign ex_pc          = st_q.pc;
  assign ex_reg_write   = st_q.reg_write;
  assign ex_mem_read    = st_q.mem_read;
  assign ex_mem_write   = st_q.mem_write;
  assign ex_mem_to_reg  = st_q.mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// behavioural model of the EX slot contents.

`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 0, flush = 0, id_valid = 0;
  logic [31:0] id_pc = 0, id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic        id_alu_src = 0, id_reg_dst = 0;
  logic [2:0]  id_alu_control = 0;
  logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;
  logic        exmem_reg_write = 0;
  logic [4:0]  exmem_dest = 0;
  logic [31:0] exmem_result = 0;
  logic        memwb_reg_write = 0;
  logic [4:0]  memwb_dest = 0;
  logic [31:0] memwb_data = 0;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_dest;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_alu_control(ex_alu_control), .ex_dest(ex_dest), .ex_pc(ex_pc),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // What instruction currently sits in EX, as the pipeline sees it.
  typedef struct {
    logic        v;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dest;
    logic        asrc;
    logic [2:0]  ctl;
    logic        rw, mr, mw, m2r;
  } ex_t;

  ex_t m;
  ex_t bubble = '{v: 0, pc: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, dest: 0,
                  asrc: 0, ctl: 0, rw: 0, mr: 0, mw: 0, m2r: 0};

  // Value register `idx` holds right now, given in-flight writes.
  function automatic logic [31:0] reg_value(logic [4:0] idx, logic [31:0] stale);
    if (idx == 0) return stale;
    if (exmem_reg_write && exmem_dest == idx) return exmem_result;
    if (memwb_reg_write && memwb_dest == idx) return memwb_data;
    return stale;
  endfunction

  function automatic logic model_hazard();
    if (!(m.v && m.mr && m.dest != 0 && id_valid)) return 1'b0;
    if (m.dest == id_rs) return 1'b1;
    return (m.dest == id_rt) && (!id_alu_src || id_mem_write);
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = m;
    if (flush || (!stall && model_hazard())) return bubble;
    if (stall) begin
      n.rsd = reg_value(m.rs, m.rsd);
      n.rtd = reg_value(m.rt, m.rtd);
      return n;
    end
    n.v = id_valid; n.pc = id_pc; n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
    n.rs = id_rs; n.rt = id_rt; n.dest = id_reg_dst ? id_rd : id_rt; n.asrc = id_alu_src;
    n.ctl = id_valid ? id_alu_control : 3'b000;
    n.rw = id_valid & id_reg_write; n.mr = id_valid & id_mem_read;
    n.mw = id_valid & id_mem_write; n.m2r = id_valid & id_mem_to_reg;
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] rt_now;
    rt_now = reg_value(m.rt, m.rtd);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".a"}, ex_a, reg_value(m.rs, m.rsd));
    chk({tag, ".b"}, ex_b, m.asrc ? m.imm : rt_now);
    chk({tag, ".store"}, ex_store_data, rt_now);
    chk({tag, ".ctl"}, 32'(ex_alu_control), 32'(m.ctl));
    chk({tag, ".dest"}, 32'(ex_dest), 32'(m.dest));
    chk({tag, ".pc"}, ex_pc, m.pc);
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(m.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(m.mr));
    chk({tag, ".mw"}, 32'(ex_mem_write), 32'(m.mw));
    chk({tag, ".m2r"}, 32'(ex_mem_to_reg), 32'(m.m2r));
    chk({tag, ".haz"}, 32'(load_use_hazard), 32'(model_hazard()));
  endtask

  // Called just after a negedge: check pre-edge view, clock, check post-edge view.
  task automatic cycle(string tag);
    ex_t n;
    #1;
    check_all({tag, "/pre"});
    n = model_next();
    @(posedge clk);
    m = n;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_instr(logic v, logic [31:0] pc, logic [31:0] rsd, logic [31:0] rtd,
                           logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic asrc,
                           logic rdst, logic [2:0] ctl, logic rw, logic mr, logic mw);
    id_valid = v; id_pc = pc; id_rs_data = rsd; id_rt_data = rtd; id_rs = rs; id_rt = rt;
    id_rd = rd; id_alu_src = asrc; id_reg_dst = rdst; id_alu_control = ctl;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_dest = 0; memwb_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b010; ops[1] = 3'b110; ops[2] = 3'b000; ops[3] = 3'b001; ops[4] = 3'b111;
    m = bubble;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Basic pass-through
    id_imm = 32'h1234;
    set_instr(1, 32'h100, 5, 7, 1, 2, 9, 0, 1, 3'b010, 1, 0, 0);
    cycle("basic");
    chk("basic.a5", ex_a, 32'd5);
    chk("basic.b7", ex_b, 32'd7);
    chk("basic.dest9", 32'(ex_dest), 32'd9);
    chk("basic.valid1", 32'(ex_valid), 32'd1);

    // Forward priority, stage held by stall
    set_instr(1, 32'h104, 1, 2, 3, 8, 0, 0, 0, 3'b010, 1, 0, 0);
    cycle("fwd_load");
    stall = 1;
    exmem_reg_write = 1; exmem_dest = 3; exmem_result = 32'h20;
    memwb_reg_write = 1; memwb_dest = 3; memwb_data = 32'h30;
    #1 chk("fwd.exmem", ex_a, 32'h20);
    exmem_reg_write = 0;
    #1 chk("fwd.memwb", ex_a, 32'h30);
    memwb_dest = 0;
    #1 chk("fwd.none", ex_a, 32'h1);
    no_fwd();
    stall = 0;

    // Load-use: lw $4 then add using $4
    set_instr(1, 32'h108, 0, 0, 2, 4, 0, 1, 0, 3'b010, 1, 1, 0);
    cycle("lw");
    set_instr(1, 32'h10c, 32'h111, 32'h5, 4, 5, 7, 0, 1, 3'b010, 1, 0, 0);
    #1 chk("lu.haz", 32'(load_use_hazard), 32'd1);
    cycle("lu.bubble");
    chk("lu.valid0", 32'(ex_valid), 32'd0);
    chk("lu.rw0", 32'(ex_reg_write), 32'd0);
    memwb_reg_write = 1; memwb_dest = 4; memwb_data = 32'hDEAD;
    cycle("lu.add");
    chk("lu.fwd", ex_a, 32'hDEAD);
    no_fwd();

    // Stall with a MEM/WB write retiring in the first stalled cycle
    set_instr(1, 32'h110, 0, 32'h11, 0, 6, 2, 0, 1, 3'b001, 1, 0, 0);
    cycle("st_load");
    stall = 1;
    memwb_reg_write = 1; memwb_dest = 6; memwb_data = 32'hAB;
    cycle("st1");
    no_fwd();
    cycle("st2");
    cycle("st3");
    chk("st.b", ex_b, 32'hAB);
    stall = 0;

    // Flush beats stall
    set_instr(1, 32'h114, 3, 4, 1, 2, 3, 0, 1, 3'b111, 1, 1, 1);
    cycle("fs_load");
    flush = 1; stall = 1;
    cycle("fs");
    chk("fs.valid", 32'(ex_valid), 32'd0);
    chk("fs.ctl", 32'(ex_alu_control), 32'd0);
    chk("fs.mw", 32'(ex_mem_write), 32'd0);
    flush = 0; stall = 0;

    // Asynchronous reset mid-operation
    set_instr(1, 32'h118, 32'h55, 32'h66, 1, 2, 3, 0, 1, 3'b110, 1, 0, 0);
    cycle("rs_load");
    #1 rst = 1'b0;
    m = bubble;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.a", ex_a, 32'd0);
    chk("arst.pc", ex_pc, 32'd0);
    chk("arst.rw", 32'(ex_reg_write), 32'd0);
    check_all("arst");
    #1 rst = 1'b1;
    cycle("arst.rel");
    chk("arst.pc_load", ex_pc, 32'h118);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
      id_alu_control = ops[$urandom_range(0, 4)];
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0); id_mem_to_reg = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_dest = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_dest = 5'($urandom_range(0, 7));
      memwb_data = $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
